l2_evict_ctrl: RTL
==================

Name: l2_evict_ctrl

Overview:
- Victim-selection and eviction controller for the 8-way split L2 cache. It is the freeing counterpart of the fill path's empty-way lookup.
- On request for a set index, it reads that set's MESI, LRU and tag state and chooses a way:
  - the first invalid way, if any;
  - otherwise the LRU way.
- A Modified victim is written back to the next level through a valid/ready handshake, then the way is invalidated. The freed way number is reported to the fill logic.

Parameters:
- WAYS, 8, associativity.
- WAY_W, 3, way-number width.
- INDEX_W, 14, set-index width.
- TAG_W, 12, tag width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- evict_req  in  1  start eviction for evict_index; honoured only when busy=0.
- evict_index  in  INDEX_W  set to free a way in.
- busy  out  1  controller not idle.
- evict_ack  out  1  one-cycle pulse: way freed.
- evict_way  out  WAY_W  freed way, valid with evict_ack.
- evict_wb  out  1  writeback performed, valid with evict_ack.
- arr_rd_en  out  1  state-array read strobe.
- arr_rd_index  out  INDEX_W  set to read.
- arr_mesi  in  2*WAYS  per-way MESI, way w at bits [2w+1:2w]; valid the cycle after arr_rd_en.
- arr_lru  in  WAY_W*WAYS  per-way LRU rank, 7 = least recent; same timing.
- arr_tags  in  TAG_W*WAYS  per-way tag; same timing.
- wb_valid  out  1  writeback request.
- wb_ready  in  1  next level accepts writeback.
- wb_addr  out  TAG_W+INDEX_W  {victim tag, index}.
- inv_en  out  1  one-cycle invalidate strobe to the state array.
- inv_index  out  INDEX_W  set to invalidate.
- inv_way  out  WAY_W  way to invalidate.

Behaviour:
- MESI encoding: I=00, S=01, E=10, M=11.
- Reset (asynchronous, rst_n=0):
  - state goes to IDLE;
  - every output goes to 0, including busy, evict_ack, wb_valid, inv_en and all data outputs;
  - latched index and way are cleared.
- Reset mid-operation aborts immediately; wb_valid drops even if unaccepted (intended, and the next level is reset too).
- FSM states: IDLE, READ, SELECT, WB, INV, DONE. busy = (state != IDLE).
- IDLE:
  - if evict_req is high, latch evict_index and go to READ;
  - evict_req while busy is ignored and not queued.
- READ: arr_rd_en=1 for exactly one cycle, arr_rd_index = latched index, go to SELECT.
- SELECT: sample the arr_* inputs.
  - If any way has MESI=I: victim = lowest-numbered invalid way, no writeback, no invalidate, evict_wb=0, go to DONE.
  - Else victim = way with the maximum LRU rank; ties go to the lowest way number.
  - If the victim is M: form wb_addr = {tag[victim], index}, go to WB.
  - Otherwise go to INV.
- WB:
  - wb_valid=1 with wb_addr held stable until the cycle wb_ready=1;
  - the transfer occurs on that cycle, then go to INV with evict_wb recorded as 1;
  - wb_ready outside WB is ignored.
- INV: inv_en=1 for one cycle with inv_index/inv_way = latched index/victim, go to DONE.
- DONE: evict_ack=1 for one cycle with evict_way/evict_wb valid, go to IDLE.
- evict_way and evict_wb hold their values until the next DONE; evict_ack pulses only once per request.
- Latency, with the request sampled at edge 0:
  - empty-way case: ack in cycle 3;
  - clean victim: ack in cycle 4;
  - dirty victim with wb_ready tied high: ack in cycle 5;
  - each wb_ready stall cycle adds 1.
- Back-to-back: a new evict_req can be accepted in the cycle after DONE.
- X or Z on arr_* outside the sample cycle must not affect outputs.

Test Plan:
- Reset: assert rst_n=0 mid-WB -> in the same cycle wb_valid=0 and busy=0; all outputs are 0 after release.
- Empty way: index 0, ways 0-6 valid (S), way 7 invalid -> evict_ack in cycle 3 with evict_way=7, evict_wb=0, no inv_en, no wb_valid.
- Clean LRU: all ways E, lru = way w rank w (way 7 rank 7) -> inv_en with inv_way=7, ack in cycle 4, evict_wb=0.
- Dirty with stall: all valid, way 2 is M with rank 7, tag 12'h111, index 5, wb_ready low for 3 cycles -> wb_valid held 4 cycles with wb_addr={12'h111,14'd5}, then inv_way=2, ack in cycle 8, evict_wb=1.
- Tie and ignore: two ways at rank 7 (ways 3 and 6) -> victim is way 3; a second evict_req while busy produces no second ack.
- Back-to-back: evict_req held high across DONE -> second request accepted the cycle after the first ack, producing exactly two acks.

Source files
------------

// File: rtl/l2_evict_ctrl.sv
// L2 eviction controller: frees one way of a set (first invalid way, else LRU),
// writing back a Modified victim and invalidating it before reporting the way.
module l2_evict_ctrl #(
  parameter int WAYS    = 8,
  parameter int WAY_W   = 3,
  parameter int INDEX_W = 14,
  parameter int TAG_W   = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     evict_req,
  input  logic [INDEX_W-1:0]       evict_index,
  output logic                     busy,
  output logic                     evict_ack,
  output logic [WAY_W-1:0]         evict_way,
  output logic                     evict_wb,
  output logic                     arr_rd_en,
  output logic [INDEX_W-1:0]       arr_rd_index,
  input  logic [2*WAYS-1:0]        arr_mesi,
  input  logic [WAY_W*WAYS-1:0]    arr_lru,
  input  logic [TAG_W*WAYS-1:0]    arr_tags,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [TAG_W+INDEX_W-1:0] wb_addr,
  output logic                     inv_en,
  output logic [INDEX_W-1:0]       inv_index,
  output logic [WAY_W-1:0]         inv_way
);

  // state  | meaning
  // IDLE   | waiting for evict_req
  // READ   | state-array read strobe for the latched set
  // SELECT | array data valid; choose victim
  // WB     | dirty victim offered to next level
  // INV    | invalidate strobe for the victim
  // DONE   | ack pulse with freed way
  typedef enum logic [2:0] {IDLE, READ, SELECT, WB, INV, DONE} state_t;

  state_t                     state_q, state_d;
  logic [INDEX_W-1:0]         idx_q;
  logic [WAY_W-1:0]           victim_q;
  logic [TAG_W+INDEX_W-1:0]   wb_addr_q;
  logic                       wb_done_q;
  logic [WAY_W-1:0]           evict_way_q;
  logic                       evict_wb_q;

  logic                       inv_found;
  logic [WAY_W-1:0]           inv_way_sel;
  logic [WAY_W-1:0]           lru_way_sel;
  logic [WAY_W-1:0]           lru_best;
  logic [TAG_W-1:0]           lru_tag;
  logic                       lru_dirty;
  logic [WAY_W-1:0]           victim_sel;

  // Strict '>' keeps the lowest way on LRU rank ties.
  always_comb begin
    inv_found   = 1'b0;
    inv_way_sel = '0;
    lru_way_sel = '0;
    lru_best    = arr_lru[WAY_W-1:0];
    lru_tag     = arr_tags[TAG_W-1:0];
    lru_dirty   = (arr_mesi[1:0] == 2'b11);
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && arr_mesi[2*w +: 2] == 2'b00) begin
        inv_found   = 1'b1;
        inv_way_sel = WAY_W'(w);
      end
      if (arr_lru[WAY_W*w +: WAY_W] > lru_best) begin
        lru_best    = arr_lru[WAY_W*w +: WAY_W];
        lru_way_sel = WAY_W'(w);
        lru_tag     = arr_tags[TAG_W*w +: TAG_W];
        lru_dirty   = (arr_mesi[2*w +: 2] == 2'b11);
      end
    end
    victim_sel = inv_found ? inv_way_sel : lru_way_sel;
  end

  always_comb begin
    state_d   = state_q;
    arr_rd_en = 1'b0;
    wb_valid  = 1'b0;
    inv_en    = 1'b0;
    evict_ack = 1'b0;
    case (state_q)
      IDLE:   if (evict_req) state_d = READ;
      READ: begin
        arr_rd_en = 1'b1;
        state_d   = SELECT;
      end
      SELECT: begin
        if (inv_found)      state_d = DONE;
        else if (lru_dirty) state_d = WB;
        else                state_d = INV;
      end
      WB: begin
        wb_valid = 1'b1;
        if (wb_ready) state_d = INV;
      end
      INV: begin
        inv_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        evict_ack = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      victim_q    <= '0;
      wb_addr_q   <= '0;
      wb_done_q   <= 1'b0;
      evict_way_q <= '0;
      evict_wb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && evict_req) idx_q <= evict_index;
      if (state_q == SELECT) begin
        victim_q  <= victim_sel;
        wb_done_q <= 1'b0;
        if (!inv_found && lru_dirty) wb_addr_q <= {lru_tag, idx_q};
        if (inv_found) begin
          evict_way_q <= victim_sel;
          evict_wb_q  <= 1'b0;
        end
      end
      if (state_q == WB && wb_ready) wb_done_q <= 1'b1;
      if (state_q == INV) begin
        evict_way_q <= victim_q;
        evict_wb_q  <= wb_done_q;
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign arr_rd_index = idx_q;
  assign inv_index    = idx_q;
  assign inv_way      = victim_q;
  assign wb_addr      = wb_addr_q;
  assign evict_way    = evict_way_q;
  assign evict_wb     = evict_wb_q;

endmodule
